// File: rtl/fp_link_pkg.sv
// Shared dual-rail helpers for the FP link receiver: codeword constants, FSM state type and per-bit decode.
// FP_RX_ILLEGAL_CHK_EN makes 2'b11 count as incomplete rather than as logic 1.
package fp_link_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic {
    RX_IDLE,
    RX_WAIT_NULL
  } rx_state_e;

  // Per-bit helpers; callers reduce them over their own token width.
  function automatic logic dr_is_complete(input logic [1:0] r);
`ifdef FP_RX_ILLEGAL_CHK_EN
    return (r == DR_ZERO) || (r == DR_ONE);
`else
    return r != DR_NULL;
`endif
  endfunction

  function automatic logic dr_is_null(input logic [1:0] r);
    return r == DR_NULL;
  endfunction

  function automatic logic dr_is_illegal(input logic [1:0] r);
    return r == DR_ILL;
  endfunction

  function automatic logic dr_decode(input logic [1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/fp_link_rx_sync_if.sv
// Link-side and consumer-side signals of the FP receiver; slave is the receiver, master the environment.
interface fp_link_rx_sync_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0][1:0] in;
  logic                  ack_o;
  logic [WIDTH-1:0]      data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  err_o;

  modport slave (
    input  in, ready_i,
    output ack_o, data_o, valid_o, err_o
  );

  modport master (
    output in, ready_i,
    input  ack_o, data_o, valid_o, err_o
  );
endinterface

// File: rtl/fp_link_rx_sync_sync.sv
// Plain multi-flop synchroniser, synchronously reset to 0; q lags d by STAGES clocks.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fp_link_rx_sync.sv
// Clocked four-phase dual-rail receiver: synchronise rails, detect complete/null, ack, and hold token in a 1-entry slot.
// Optional sticky illegal-codeword flag under FP_RX_ILLEGAL_CHK_EN.
module fp_link_rx_sync
  import fp_link_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  fp_link_rx_sync_if.slave  bus
);

  logic [2*WIDTH-1:0]    rails_flat;
  logic [2*WIDTH-1:0]    in_s_flat;
  logic [WIDTH-1:0][1:0] in_s;

  assign rails_flat = bus.in;

  sync_ff #(.WIDTH(2*WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rails_flat),
    .q   (in_s_flat)
  );

  assign in_s = in_s_flat;

  logic             complete;
  logic             is_null;
  logic [WIDTH-1:0] decoded;

  always_comb begin
    complete = 1'b1;
    is_null  = 1'b1;
    decoded  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      complete   = complete & dr_is_complete(in_s[i]);
      is_null    = is_null & dr_is_null(in_s[i]);
      decoded[i] = dr_decode(in_s[i]);
    end
  end

  rx_state_e        state, state_nxt;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             capture;

  // Only capture when the slot is free or being drained this very edge.
  assign capture = (state == RX_IDLE) && complete && (!valid || bus.ready_i);

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:      if (capture) state_nxt = RX_WAIT_NULL;
      RX_WAIT_NULL: if (is_null) state_nxt = RX_IDLE;
      default:      state_nxt = RX_IDLE;
    endcase
  end

  // ack is a pure decode of the state register, so it only moves on transitions.
  always_comb begin
    bus.ack_o = (state == RX_WAIT_NULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= decoded;
    end else if (bus.ready_i) begin
      valid <= 1'b0;
    end
  end

  assign bus.valid_o = valid;
  assign bus.data_o  = data;

`ifdef FP_RX_ILLEGAL_CHK_EN
  logic illegal;
  logic err;

  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < WIDTH; i++) illegal = illegal | dr_is_illegal(in_s[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end

  assign bus.err_o = err;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
